multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control FSM and decoders that sequence a multi-cycle RV32I-subset datapath. The datapath shares one memory for instructions and data, and one ALU for PC increment, address generation and execution. This block replaces the fixed tie-offs used for alu_op, write_en and src_b selection in the single-cycle core with per-state control. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

Parameters:
ALU_CTRL_WIDTH, 3, width of alu_control; matches the alu module alu_op input.
STATE_WIDTH, 4, width of the debug state output.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag, from the current-cycle ALU result
pc_write  output  1  PC register load enable
adr_src  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  memory write enable
ir_write  output  1  instruction register / OldPC load enable
result_src  output  2  result select: 00=ALUOut, 01=memory data, 10=ALU result
alu_src_a  output  2  ALU A select: 00=PC, 01=OldPC, 10=reg A
alu_src_b  output  2  ALU B select: 00=reg B, 01=imm_ext, 10=constant 4
alu_control  output  ALU_CTRL_WIDTH  operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
reg_write  output  1  register file write enable
imm_src  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
illegal_instr  output  1  one-cycle pulse when DECODE sees an unsupported opcode
state  output  STATE_WIDTH  current state encoding, for debug

Behaviour:
- Moore FSM; state register uses async reset on rst_n low. All outputs are decoded combinationally from state, except:
  - imm_src: from opcode only.
  - alu_control: from alu_op, funct3, funct7b5 and opcode[5].
  - pc_write and illegal_instr: see rules below.
- State encodings: RESET=11, FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 12-15 are unused and go to RESET on the next clock.
- Reset behaviour:
  - While rst_n=0, state=RESET and all enables (pc_write, ir_write, mem_write, reg_write, illegal_instr) are 0.
  - All selects are 0; alu_control=000.
  - The first clock after deassertion enters FETCH.
  - Reset asserted in any state forces RESET immediately; no write strobe may be asserted during it.
- Per-state controls (unlisted outputs are 0):
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=add, result_src=10, pc_update=1. Next state is DECODE.
  - DECODE: src_a=01, src_b=01, alu_op=add (branch/jump target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH, with illegal_instr=1 for this cycle.
  - MEMADR: src_a=10, src_b=01, alu_op=add. Next state is MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Next state is MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next state is FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next state is FETCH.
  - EXECUTER: src_a=10, src_b=00, alu_op=funct. Next state is ALUWB.
  - EXECUTEI: src_a=10, src_b=01, alu_op=funct. Next state is ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next state is FETCH.
  - JAL: src_a=01, src_b=10, alu_op=add, result_src=00, pc_update=1. Next state is ALUWB, which writes OldPC+4 to rd.
  - BEQ: src_a=10, src_b=00, alu_op=sub, result_src=00, branch=1. Next state is FETCH.
- pc_write = pc_update | (branch & zero).
- alu_control decoding:
  - alu_op=add -> 000; alu_op=sub -> 001.
  - alu_op=funct, by funct3:
    - 000 -> 001 if opcode[5]=1 and funct7b5=1, else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - any other funct3 -> 000
- CPI: lw=5, sw=4, R-type=4, I-type=4, jal=4, beq=3, illegal=2.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> state=11 and all enables 0. Release rst_n -> next edge state=0, ir_write=1, pc_write=1, src_b=10.
- lw (opcode 0000011) -> states 0,1,2,3,4,0. Only MEMWB has reg_write=1. MEMREAD has adr_src=1. imm_src=00.
- sw (opcode 0100011) -> states 0,1,2,5,0. mem_write=1 for exactly 1 cycle. reg_write never 1. imm_src=01.
- R-type sub (0110011, funct3=000, funct7b5=1) -> EXECUTER with alu_control=001. Same fields with funct7b5=0 -> 000. addi (0010011) with funct7b5=1 -> 000.
- beq: zero=1 in BEQ -> pc_write=1. zero=0 -> pc_write=0. Both paths return to FETCH after 3 cycles total.
- jal -> states 0,1,9,7,0; pc_write=1 in JAL. Opcode 1111111 -> DECODE then FETCH, with a 1-cycle illegal_instr pulse. Forcing state 13 -> RESET on the next edge. rst_n low mid-MEMWRITE -> mem_write drops to 0 asynchronously.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM and decoders for the multi-cycle RV32I-subset datapath.
// The datapath has one shared memory and one shared ALU, so each instruction
// is split into several states. Each state drives the selects and strobes.
module multicycle_controller #(
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int STATE_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic                      funct7b5,
    input  logic                      zero,
    output logic                      pc_write,
    output logic                      adr_src,
    output logic                      mem_write,
    output logic                      ir_write,
    output logic [1:0]                result_src,
    output logic [1:0]                alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic                      reg_write,
    output logic [1:0]                imm_src,
    output logic                      illegal_instr,
    output logic [STATE_WIDTH-1:0]    state
);

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH    = 0,
        S_DECODE   = 1,
        S_MEMADR   = 2,
        S_MEMREAD  = 3,
        S_MEMWB    = 4,
        S_MEMWRITE = 5,
        S_EXECUTER = 6,
        S_ALUWB    = 7,
        S_EXECUTEI = 8,
        S_JAL      = 9,
        S_BEQ      = 10,
        S_RESET    = 11
    } state_e;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_FUNCT = 2'd2
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_update;
    logic    branch;

    // State register; reset forces RESET immediately so every strobe drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Next state and Moore controls for the current state.
    always_comb begin
        state_d       = S_RESET;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = AOP_ADD;
        reg_write     = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = AOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = AOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // OldPC+4 lands in ALUOut for ALUWB; target from DECODE loads PC.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = AOP_SUB;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    // Immediate format follows the opcode alone.
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // ALU decode; funct7b5 selects sub only for register-register ops.
    always_comb begin
        alu_control = ALU_CTRL_WIDTH'(3'b000);
        case (alu_op)
            AOP_SUB:   alu_control = ALU_CTRL_WIDTH'(3'b001);
            AOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (opcode[5] && funct7b5) ? ALU_CTRL_WIDTH'(3'b001)
                                                                    : ALU_CTRL_WIDTH'(3'b000);
                    3'b010:  alu_control = ALU_CTRL_WIDTH'(3'b101);
                    3'b110:  alu_control = ALU_CTRL_WIDTH'(3'b011);
                    3'b111:  alu_control = ALU_CTRL_WIDTH'(3'b010);
                    default: alu_control = ALU_CTRL_WIDTH'(3'b000);
                endcase
            end
            default:   alu_control = ALU_CTRL_WIDTH'(3'b000);
        endcase
    end

    assign pc_write = pc_update | (branch & zero);
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: a per-cycle table of
// inputs and expected outputs, then hand sequences for CPI and async reset.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    multicycle_controller #(.ALU_CTRL_WIDTH(3), .STATE_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_write(reg_write), .imm_src(imm_src),
        .illegal_instr(illegal_instr), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // {state,pc_write,adr_src,mem_write,ir_write,result_src,src_a,src_b,alu_control,reg_write,imm_src,illegal}
    function automatic logic [20:0] pk(logic [3:0] st, logic pcw, logic adr, logic mw, logic irw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic [2:0] alu, logic rw, logic [1:0] imm, logic ill);
        return {st, pcw, adr, mw, irw, rs, sa, sb, alu, rw, imm, ill};
    endfunction

    function automatic logic [20:0] f_row(logic [1:0] imm);
        return pk(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0);
    endfunction

    function automatic logic [20:0] d_row(logic [1:0] imm, logic ill);
        return pk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, ill);
    endfunction

    function automatic logic [20:0] wb_row(logic [1:0] imm);
        return pk(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, imm, 0);
    endfunction

    task automatic add(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [20:0] exp);
        vec_t v;
        v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One R-type pass: FETCH, DECODE, EXECUTER, ALUWB
    task automatic add_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        add(1, RT, f3, f7, 1, f_row(2'b00));
        add(1, RT, f3, f7, 1, d_row(2'b00, 0));
        add(1, RT, f3, f7, 1, pk(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, 2'b00, 0));
        add(1, RT, f3, f7, 1, wb_row(2'b00));
    endtask

    task automatic add_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        add(1, IT, f3, f7, 1, f_row(2'b00));
        add(1, IT, f3, f7, 1, d_row(2'b00, 0));
        add(1, IT, f3, f7, 1, pk(4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0, 2'b00, 0));
        add(1, IT, f3, f7, 1, wb_row(2'b00));
    endtask

    task automatic add_beq(input logic z);
        add(1, BEQ, 3'b000, 0, 0, f_row(2'b10));
        add(1, BEQ, 3'b000, 0, 0, d_row(2'b10, 0));
        add(1, BEQ, 3'b000, 0, z, pk(4'd10, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 2'b10, 0));
    endtask

    function automatic logic [20:0] act();
        return pk(state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_control, reg_write, imm_src, illegal_instr);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From FETCH, run one instruction and count clocks until FETCH again.
    task automatic cpi(input logic [6:0] op, input int exp_n, input string name);
        int n;
        opcode = op; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (state != 4'd0 && n < 20);
        check(name, 32'(n), 32'(exp_n));
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

        // reset held 3 cycles, then released (still RESET until the edge)
        repeat (3) add(0, 7'd0, 3'd0, 0, 1, pk(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0));
        add(1, 7'd0, 3'd0, 0, 1, pk(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0));
        // lw
        add(1, LW, 3'b010, 0, 1, f_row(2'b00));
        add(1, LW, 3'b010, 0, 1, d_row(2'b00, 0));
        add(1, LW, 3'b010, 0, 1, pk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b00, 0));
        add(1, LW, 3'b010, 0, 1, pk(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0));
        add(1, LW, 3'b010, 0, 1, pk(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 2'b00, 0));
        // sw
        add(1, SW, 3'b010, 1, 1, f_row(2'b01));
        add(1, SW, 3'b010, 1, 1, d_row(2'b01, 0));
        add(1, SW, 3'b010, 1, 1, pk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b01, 0));
        add(1, SW, 3'b010, 1, 1, pk(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b01, 0));
        // R-type: sub, add, slt, or, and, unlisted funct3
        add_r(3'b000, 1, 3'b001);
        add_r(3'b000, 0, 3'b000);
        add_r(3'b010, 0, 3'b101);
        add_r(3'b110, 0, 3'b011);
        add_r(3'b111, 0, 3'b010);
        add_r(3'b001, 1, 3'b000);
        // I-type: addi with funct7b5 set stays add, slti
        add_i(3'b000, 1, 3'b000);
        add_i(3'b010, 0, 3'b101);
        // beq taken / not taken
        add_beq(1);
        add_beq(0);
        // jal
        add(1, JAL, 3'b000, 0, 1, f_row(2'b11));
        add(1, JAL, 3'b000, 0, 1, d_row(2'b11, 0));
        add(1, JAL, 3'b000, 0, 0, pk(4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 2'b11, 0));
        add(1, JAL, 3'b000, 0, 1, wb_row(2'b11));
        // illegal opcode: DECODE pulses illegal_instr and returns to FETCH
        add(1, BAD, 3'b000, 0, 1, f_row(2'b00));
        add(1, BAD, 3'b000, 0, 1, d_row(2'b00, 1));
        add(1, BAD, 3'b000, 0, 1, f_row(2'b00));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst; opcode = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; zero = vecs[i].z;
            #1;
            check($sformatf("vec%0d", i), 32'(act()), 32'(vecs[i].exp));
            step();
        end

        // clean restart for the CPI sequences
        rst_n = 1'b0; #1;
        check("async_reset_state", 32'(state), 32'd11);
        step();
        rst_n = 1'b1;
        step();
        check("fetch_after_reset", 32'(state), 32'd0);
        cpi(LW,  5, "cpi_lw");
        cpi(SW,  4, "cpi_sw");
        cpi(RT,  4, "cpi_r");
        cpi(IT,  4, "cpi_i");
        cpi(JAL, 4, "cpi_jal");
        cpi(BEQ, 3, "cpi_beq");
        cpi(BAD, 2, "cpi_illegal");

        // reset dropped in the middle of MEMWRITE kills mem_write without a clock
        opcode = SW;
        begin
            int n;
            n = 0;
            while (state != 4'd5 && n < 10) begin
                step();
                n++;
            end
        end
        check("memwrite_reached", 32'({state, mem_write}), 32'({4'd5, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("memwrite_async_drop", 32'({state, mem_write, pc_write, ir_write, reg_write}),
              32'({4'd11, 4'b0000}));
        step();
        rst_n = 1'b1;
        step();
        check("fetch_after_mid_reset", 32'({state, ir_write, pc_write}), 32'({4'd0, 2'b11}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
